pe_node_ctrl: RTL and testbench

Sequencing controller for the PE node-state path: accepts scattered packets from the network with a valid/ready handshake and performs a pipelined read-modify-write on node memory. In relax mode it emits an update packet whenever node state improves. It drives a node memory with one read port and one write port (1-cycle registered read), sits between the network interface and the PE output, and raises `pe_done` once a last-flagged packet has fully drained.

---
 rtl/pe_node_ctrl_pkg.sv | 28 ++
 rtl/pe_out_reg.sv | 26 ++
 rtl/pe_node_ctrl.sv | 128 ++++++++++++
 tb/tb_pe_node_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pe_node_ctrl_pkg.sv
// Shared definitions for the PE node-state controller: mode encodings and
// packet layout {last, addr, val} derived from the address/value widths.
package pe_node_ctrl_pkg;

  typedef enum logic [1:0] {
    CONF_RELAX = 2'b00,
    CONF_LOAD  = 2'b01,
    CONF_DROP  = 2'b10,
    CONF_DROP2 = 2'b11
  } conf_mode_e;

  function automatic int unsigned pkt_w(input int unsigned node_w, input int unsigned val_w);
    return 1 + node_w + val_w;
  endfunction

  function automatic int unsigned val_lsb();
    return 0;
  endfunction

  function automatic int unsigned addr_lsb(input int unsigned val_w);
    return val_w;
  endfunction

  function automatic int unsigned last_bit(input int unsigned node_w, input int unsigned val_w);
    return node_w + val_w;
  endfunction

endpackage

// File: rtl/pe_out_reg.sv
// Single-entry valid/ready output register; may reload in the cycle it is consumed.
module pe_out_reg #(
  parameter int unsigned W = 27
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pe_node_ctrl.sv
// Two-stage read-modify-write controller for PE node state with update output.
// Optional statistics counters are enabled by defining PE_CTRL_STATS_EN.
module pe_node_ctrl #(
  parameter int unsigned NODE_W = 10,
  parameter int unsigned VAL_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              conf_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NODE_W+VAL_W:0]   in_packet,
  output logic [NODE_W-1:0]       nmem_rdaddr,
  input  logic [VAL_W-1:0]        nmem_rdq,
  output logic [NODE_W-1:0]       nmem_wraddr,
  output logic [VAL_W-1:0]        nmem_wrdata,
  output logic                    nmem_wren,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NODE_W+VAL_W:0]   out_packet,
  output logic                    pe_done
`ifdef PE_CTRL_STATS_EN
  ,
  output logic [31:0]             stat_accepted,
  output logic [31:0]             stat_updates
`endif
);
  import pe_node_ctrl_pkg::*;

  localparam int unsigned PKT_W    = pkt_w(NODE_W, VAL_W);
  localparam int unsigned VAL_LSB  = val_lsb();
  localparam int unsigned ADDR_LSB = addr_lsb(VAL_W);
  localparam int unsigned LAST_BIT = last_bit(NODE_W, VAL_W);

  logic              s1_valid, s1_last;
  logic [NODE_W-1:0] s1_addr;
  logic [VAL_W-1:0]  s1_val;
  conf_mode_e        s1_mode;

  logic              wr_last_valid;
  logic [NODE_W-1:0] wr_last_addr;
  logic [VAL_W-1:0]  wr_last_data;

  logic              last_seen, done_r;
  logic [VAL_W-1:0]  cur;
  logic              bypass, improve, s1_emits, s1_writes, stall, accept;
  logic              out_load, out_valid_n, last_seen_n, done_set;

  always_comb begin
    bypass      = wr_last_valid && (wr_last_addr == s1_addr);
    cur         = bypass ? wr_last_data : nmem_rdq;
    improve     = s1_val < cur;
    s1_emits    = (s1_mode == CONF_RELAX) && improve;
    s1_writes   = s1_emits || (s1_mode == CONF_LOAD);
    stall       = out_valid && !out_ready && s1_valid && s1_emits;
    in_ready    = !rst && !stall;
    accept      = in_valid && in_ready;
    // A stalled S1 re-reads its own address so nmem_rdq is fresh when it retires.
    nmem_rdaddr = stall ? s1_addr : in_packet[ADDR_LSB +: NODE_W];
    nmem_wren   = !rst && s1_valid && !stall && s1_writes;
    nmem_wraddr = s1_addr;
    nmem_wrdata = s1_val;
    out_load    = !rst && s1_valid && !stall && s1_emits;
    // Done is judged on next-cycle occupancy so it rises together with the drain.
    out_valid_n = out_load || (out_valid && !out_ready);
    last_seen_n = last_seen || (s1_valid && !stall && s1_last);
    done_set    = last_seen_n && !accept && !stall && !out_valid_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_last       <= 1'b0;
      s1_addr       <= '0;
      s1_val        <= '0;
      s1_mode       <= CONF_RELAX;
      wr_last_valid <= 1'b0;
      wr_last_addr  <= '0;
      wr_last_data  <= '0;
      last_seen     <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      if (!stall) begin
        s1_valid <= accept;
        if (accept) begin
          s1_last <= in_packet[LAST_BIT];
          s1_addr <= in_packet[ADDR_LSB +: NODE_W];
          s1_val  <= in_packet[VAL_LSB +: VAL_W];
          s1_mode <= conf_mode_e'(conf_mode);
        end
      end
      wr_last_valid <= nmem_wren;
      if (nmem_wren) begin
        wr_last_addr <= nmem_wraddr;
        wr_last_data <= nmem_wrdata;
      end
      last_seen <= done_set ? 1'b0 : last_seen_n;
      done_r    <= accept ? 1'b0 : (done_r || done_set);
    end
  end

  assign pe_done = done_r;

  pe_out_reg #(
    .W (PKT_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (out_load),
    .load_data ({s1_last, s1_addr, s1_val}),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_packet)
  );

`ifdef PE_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_accepted <= '0;
      stat_updates  <= '0;
    end else begin
      if (accept)    stat_accepted <= stat_accepted + 32'd1;
      if (nmem_wren) stat_updates  <= stat_updates + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_node_ctrl.sv
// Table-driven bench for pe_node_ctrl with a behavioural node memory
// (1-cycle registered read, old data on read-during-write).
module tb_pe_node_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  conf_mode;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] in_packet;
  logic [9:0]  nmem_rdaddr;
  logic [15:0] nmem_rdq;
  logic [9:0]  nmem_wraddr;
  logic [15:0] nmem_wrdata;
  logic        nmem_wren;
  logic        out_valid;
  logic        out_ready;
  logic [26:0] out_packet;
  logic        pe_done;
`ifdef PE_CTRL_STATS_EN
  logic [31:0] stat_accepted, stat_updates;
`endif

  logic [15:0] mem [1024];
  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  pe_node_ctrl #(
    .NODE_W (10),
    .VAL_W  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .conf_mode   (conf_mode),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_packet   (in_packet),
    .nmem_rdaddr (nmem_rdaddr),
    .nmem_rdq    (nmem_rdq),
    .nmem_wraddr (nmem_wraddr),
    .nmem_wrdata (nmem_wrdata),
    .nmem_wren   (nmem_wren),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_packet  (out_packet),
    .pe_done     (pe_done)
`ifdef PE_CTRL_STATS_EN
    ,
    .stat_accepted (stat_accepted),
    .stat_updates  (stat_updates)
`endif
  );

  always @(posedge clk) begin
    if (nmem_wren) mem[nmem_wraddr] <= nmem_wrdata;
    nmem_rdq <= mem[nmem_rdaddr];
  end

  typedef struct {
    logic [1:0]  mode;
    logic        iv;
    logic [26:0] pkt;
    logic        ordy;
    logic        e_irdy;
    logic        e_wren;
    logic [9:0]  e_wa;
    logic [15:0] e_wd;
    logic        e_ov;
    logic [26:0] e_op;
    logic        e_done;
  } vec_t;

  vec_t vt[$];

  function automatic logic [26:0] pk(input logic l, input logic [9:0] a, input logic [15:0] v);
    return {l, a, v};
  endfunction

  task automatic add(input logic [1:0] mode, input logic iv, input logic [26:0] pkt, input logic ordy,
                     input logic e_irdy, input logic e_wren, input logic [9:0] e_wa, input logic [15:0] e_wd,
                     input logic e_ov, input logic [26:0] e_op, input logic e_done);
    vec_t v;
    v.mode = mode; v.iv = iv; v.pkt = pkt; v.ordy = ordy;
    v.e_irdy = e_irdy; v.e_wren = e_wren; v.e_wa = e_wa; v.e_wd = e_wd;
    v.e_ov = e_ov; v.e_op = e_op; v.e_done = e_done;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] mode, input logic iv, input logic [26:0] pkt, input logic ordy);
    @(posedge clk);
    #1;
    conf_mode = mode; in_valid = iv; in_packet = pkt; out_ready = ordy;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'd100;
    rst = 1'b1; conf_mode = 2'b00; in_valid = 1'b0; in_packet = '0; out_ready = 1'b1;

    // relax improve at addr 5, then observe output
    add(0, 1, pk(0, 5, 40), 1,  1, 0, 0, 0,   0, 0, 0);
    add(0, 0, 0, 1,             1, 1, 5, 40,  0, 0, 0);
    add(0, 0, 0, 1,             1, 0, 0, 0,   1, pk(0, 5, 40), 0);
    // relax equal value: no improvement
    add(0, 1, pk(0, 5, 40), 1,  1, 0, 0, 0,   0, 0, 0);
    add(0, 0, 0, 1,             1, 0, 0, 0,   0, 0, 0);
    add(0, 0, 0, 1,             1, 0, 0, 0,   0, 0, 0);
    // back-to-back same address, second compares against bypassed 50
    add(0, 1, pk(0, 7, 50), 1,  1, 0, 0, 0,   0, 0, 0);
    add(0, 1, pk(0, 7, 60), 1,  1, 1, 7, 50,  0, 0, 0);
    add(0, 0, 0, 1,             1, 0, 0, 0,   1, pk(0, 7, 50), 0);
    add(0, 0, 0, 1,             1, 0, 0, 0,   0, 0, 0);
    // backpressure
    add(0, 1, pk(0, 9, 20), 0,  1, 0, 0, 0,   0, 0, 0);
    add(0, 1, pk(0, 10, 30), 0, 1, 1, 9, 20,  0, 0, 0);
    add(0, 1, pk(0, 11, 5), 0,  0, 0, 0, 0,   1, pk(0, 9, 20), 0);
    add(0, 1, pk(0, 11, 5), 1,  1, 1, 10, 30, 1, pk(0, 9, 20), 0);
    add(0, 0, 0, 1,             1, 1, 11, 5,  1, pk(0, 10, 30), 0);
    add(0, 0, 0, 1,             1, 0, 0, 0,   1, pk(0, 11, 5), 0);
    add(0, 0, 0, 1,             1, 0, 0, 0,   0, 0, 0);
    // load mode then done, cleared by next accept
    add(1, 1, pk(0, 3, 9), 1,   1, 0, 0, 0,   0, 0, 0);
    add(1, 1, pk(1, 4, 11), 1,  1, 1, 3, 9,   0, 0, 0);
    add(1, 0, 0, 1,             1, 1, 4, 11,  0, 0, 0);
    add(1, 0, 0, 1,             1, 0, 0, 0,   0, 0, 1);
    add(1, 0, 0, 1,             1, 0, 0, 0,   0, 0, 1);
    add(0, 1, pk(0, 3, 9), 1,   1, 0, 0, 0,   0, 0, 1);
    add(0, 0, 0, 1,             1, 0, 0, 0,   0, 0, 0);
    add(0, 0, 0, 1,             1, 0, 0, 0,   0, 0, 0);
    // drop mode: would improve in relax, but no write/output
    add(2, 1, pk(0, 5, 1), 1,   1, 0, 0, 0,   0, 0, 0);
    add(2, 0, 0, 1,             1, 0, 0, 0,   0, 0, 0);
    add(0, 0, 0, 1,             1, 0, 0, 0,   0, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", in_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst wren", nmem_wren, 0);
    chk("rst pe_done", pe_done, 0);
    chk("rst out_packet", out_packet, 0);
    chk("rst wraddr", nmem_wraddr, 0);
    chk("rst wrdata", nmem_wrdata, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post-rst in_ready", in_ready, 1);

    foreach (vt[i]) begin
      drive(vt[i].mode, vt[i].iv, vt[i].pkt, vt[i].ordy);
      chk($sformatf("row%0d in_ready", i), in_ready, vt[i].e_irdy);
      chk($sformatf("row%0d wren", i), nmem_wren, vt[i].e_wren);
      if (vt[i].e_wren) begin
        chk($sformatf("row%0d wraddr", i), nmem_wraddr, vt[i].e_wa);
        chk($sformatf("row%0d wrdata", i), nmem_wrdata, vt[i].e_wd);
      end
      chk($sformatf("row%0d out_valid", i), out_valid, vt[i].e_ov);
      if (vt[i].e_ov) chk($sformatf("row%0d out_packet", i), out_packet, vt[i].e_op);
      chk($sformatf("row%0d pe_done", i), pe_done, vt[i].e_done);
    end

    // last packet that emits: done three cycles after accept
    drive(0, 1, pk(1, 30, 1), 1);
    drive(0, 0, 0, 1);
    chk("last-emit wren", nmem_wren, 1);
    drive(0, 0, 0, 1);
    chk("last-emit out_valid", out_valid, 1);
    chk("last-emit out_packet", out_packet, pk(1, 30, 1));
    chk("last-emit done early", pe_done, 0);
    drive(0, 0, 0, 1);
    chk("last-emit done", pe_done, 1);
    chk("last-emit out drained", out_valid, 0);

    // reset mid-stream with S1 stalled behind a full output register
    drive(0, 1, pk(0, 20, 1), 0);
    drive(0, 1, pk(0, 21, 1), 0);
    chk("midrst pre write", nmem_wren, 1);
    @(posedge clk);
    #1 rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("midrst wren during rst", nmem_wren, 0);
    chk("midrst in_ready during rst", in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst out_packet", out_packet, 0);
    chk("midrst wren", nmem_wren, 0);
    chk("midrst wraddr", nmem_wraddr, 0);
    chk("midrst pe_done", pe_done, 0);
    chk("midrst in_ready", in_ready, 1);
    drive(0, 0, 0, 1);
    chk("midrst wren idle", nmem_wren, 0);
    chk("midrst mem21 untouched", mem[21], 100);
    chk("midrst mem20 written", mem[20], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
